// File: rtl/mca_sequencer_pkg.sv
// mca_sequencer_pkg: shared FSM state type and accumulator latency for mca_sequencer
package mca_sequencer_pkg;
   typedef enum logic [1:0] {SEQ_IDLE, SEQ_START, SEQ_WAIT, SEQ_CAPTURE} state_seq_e;
   localparam int MCA_LATENCY = 17;
   localparam int WAIT_W = $clog2(MCA_LATENCY);
endpackage

// File: rtl/mca_sequencer_s_window.sv
// mca_sequencer_s_window: serial control-bit window with downsampling snapshot request
module mca_sequencer_s_window #(
   parameter int NUM_ADDITIONS = 16,
   parameter int DOWNSAMPLE = 16
) (
   input  logic                     clk_i,
   input  logic                     resetn_i,
   input  logic                     enable_i,
   input  logic                     s_in_i,
   input  logic                     s_valid_i,
   output logic [NUM_ADDITIONS-1:0] win_o,
   output logic                     snap_req_o
);
   localparam int CW = $clog2(DOWNSAMPLE);
   logic [NUM_ADDITIONS-1:0] win_q, win_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic accept, last;
   always_comb begin
      accept = enable_i & s_valid_i;
      last = cnt_q == CW'(DOWNSAMPLE - 1);
      win_d = accept ? {s_in_i, win_q[NUM_ADDITIONS-1:1]} : win_q;
      cnt_d = accept ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
      snap_req_o = accept & last;
      win_o = win_d;
   end
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         win_q <= '0;
         cnt_q <= '0;
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mca_sequencer.sv
// mca_sequencer: launches one mca_add_sub run per S window snapshot and buffers each result
module mca_sequencer
   import mca_sequencer_pkg::*;
#(
   parameter int WIDTH_COEFFICIENT = 32,
   parameter int NUM_ADDITIONS = 16,
   parameter int DOWNSAMPLE = 16
) (
   input  logic                         clk_i,
   input  logic                         resetn_i,
   input  logic                         enable_i,
   input  logic                         s_in_i,
   input  logic                         s_valid_i,
   output logic [NUM_ADDITIONS-1:0]     s_values_o,
   output logic                         start_o,
   input  logic [WIDTH_COEFFICIENT-1:0] mca_res_i,
   output logic [WIDTH_COEFFICIENT-1:0] res_out_o,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic                         overrun_o
);
   state_seq_e state_q;
   logic [WAIT_W-1:0] wait_q;
   logic [NUM_ADDITIONS-1:0] s_values_q, win;
   logic [WIDTH_COEFFICIENT-1:0] res_q;
   logic start_q, valid_q, overrun_q, snap_req;
   mca_sequencer_s_window #(
      .NUM_ADDITIONS(NUM_ADDITIONS),
      .DOWNSAMPLE(DOWNSAMPLE)
   ) u_win (
      .clk_i(clk_i),
      .resetn_i(resetn_i),
      .enable_i(enable_i),
      .s_in_i(s_in_i),
      .s_valid_i(s_valid_i),
      .win_o(win),
      .snap_req_o(snap_req)
   );
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= SEQ_IDLE;
         wait_q <= '0;
         s_values_q <= '0;
         start_q <= 1'b0;
         res_q <= '0;
         valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else if (enable_i) begin
         start_q <= 1'b0;
         if (valid_q && res_ready_i) valid_q <= 1'b0;
         if (snap_req && state_q != SEQ_IDLE) overrun_q <= 1'b1;
         case (state_q)
            SEQ_IDLE: if (snap_req) begin
               s_values_q <= win;
               start_q <= 1'b1;
               state_q <= SEQ_START;
            end
            SEQ_START: begin
               wait_q <= '0;
               state_q <= SEQ_WAIT;
            end
            SEQ_WAIT: if (wait_q == WAIT_W'(MCA_LATENCY - 1)) state_q <= SEQ_CAPTURE;
               else wait_q <= wait_q + WAIT_W'(1);
            SEQ_CAPTURE: begin
               // a capture overrides a same-cycle handshake so the new result stays valid
               if (!valid_q || res_ready_i) begin
                  res_q <= mca_res_i;
                  valid_q <= 1'b1;
               end else overrun_q <= 1'b1;
               state_q <= SEQ_IDLE;
            end
            default: state_q <= SEQ_IDLE;
         endcase
      end
   end
   assign s_values_o = s_values_q;
   assign start_o = start_q;
   assign res_out_o = res_q;
   assign res_valid_o = valid_q;
   assign overrun_o = overrun_q;
endmodule

// File: tb/tb_mca_sequencer.sv
// tb_mca_sequencer: randomized scenario bench for mca_sequencer with a behavioural accumulator model
module tb_mca_sequencer;
   localparam int W = 32;
   localparam int N = 16;
   localparam int DS = 20;
   localparam int LAT = 17;
   logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, s_in = 1'b0, s_valid = 1'b0, res_ready = 1'b1;
   logic [W-1:0] mca_res, res_out;
   logic [N-1:0] s_values;
   logic start, res_valid, overrun;
   int tests = 0, fails = 0, en_edges = 0, starts = 0, t0 = 0, mc = 0;
   logic [W-1:0] m_sum = '0, junk = '0;
   logic m_q[$];
   always #5 clk = ~clk;
   mca_sequencer #(.WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(N), .DOWNSAMPLE(DS)) dut (
      .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .s_in_i(s_in), .s_valid_i(s_valid),
      .s_values_o(s_values), .start_o(start), .mca_res_i(mca_res), .res_out_o(res_out),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .overrun_o(overrun)
   );
   function automatic logic [W-1:0] ref_sum(input logic [N-1:0] w);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += w[i] ? (i + 1) : -(i + 1);
      return W'(s);
   endfunction
   function automatic logic [N-1:0] exp_win();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_q[m_q.size() - N + i];
      return r;
   endfunction
   // accumulator model: result is junk until LAT enabled cycles after the start pulse is seen
   always @(posedge clk) begin
      if (!resetn) mc <= 0;
      else if (enable) begin
         if (start) begin
            mc <= 0;
            m_sum <= ref_sum(s_values);
            starts <= starts + 1;
         end else if (mc < LAT) mc <= mc + 1;
         junk <= $urandom;
         en_edges <= en_edges + 1;
      end
   end
   assign mca_res = (mc == LAT) ? m_sum : junk;
   task automatic cyc(input logic en, input logic sv, input logic si);
      enable = en;
      s_valid = sv;
      s_in = si;
      @(posedge clk);
      if (en && sv && resetn) m_q.push_back(si);
      #1;
   endtask
   task automatic idle(input logic tog);
      if (tog) cyc(1'b0, 1'($urandom), 1'($urandom));
      cyc(1'b1, 1'b0, 1'($urandom));
   endtask
   task automatic feed(input int mode, input int gap, input logic tog);
      logic b;
      for (int k = 0; k < DS; k++) begin
         b = (mode == 3) ? 1'($urandom) : (mode == 2) ? ~k[0] : mode[0];
         repeat (gap) idle(tog);
         if (tog) cyc(1'b0, 1'($urandom), 1'($urandom));
         cyc(1'b1, 1'b1, b);
      end
      t0 = en_edges;
   endtask
   task automatic check_result(input string name, input logic tog, input int s0);
      logic [N-1:0] ew;
      logic [W-1:0] er;
      int n;
      ew = exp_win();
      er = ref_sum(ew);
      n = 0;
      while (!res_valid && n < 200) begin
         idle(tog);
         n++;
      end
      tests++;
      if (!res_valid) begin
         fails++;
         $display("FAIL %s timeout: res_valid got 0 want 1", name);
         return;
      end
      tests += 4;
      if (en_edges - t0 != 19) begin fails++; $display("FAIL %s latency: got %0d want 19", name, en_edges - t0); end
      if (s_values !== ew) begin fails++; $display("FAIL %s s_values: got %h want %h", name, s_values, ew); end
      if (res_out !== er) begin fails++; $display("FAIL %s res_out: got %0d want %0d", name, $signed(res_out), $signed(er)); end
      if (starts - s0 != 1) begin fails++; $display("FAIL %s starts: got %0d want 1", name, starts - s0); end
      idle(tog);
      tests++;
      if (res_valid !== 1'b0) begin fails++; $display("FAIL %s consume: res_valid got %b want 0", name, res_valid); end
   endtask
   task automatic check_zero(input string name);
      tests += 5;
      if (s_values !== '0) begin fails++; $display("FAIL %s s_values: got %h want 0", name, s_values); end
      if (start !== 1'b0) begin fails++; $display("FAIL %s start: got %b want 0", name, start); end
      if (res_out !== '0) begin fails++; $display("FAIL %s res_out: got %h want 0", name, res_out); end
      if (res_valid !== 1'b0) begin fails++; $display("FAIL %s res_valid: got %b want 0", name, res_valid); end
      if (overrun !== 1'b0) begin fails++; $display("FAIL %s overrun: got %b want 0", name, overrun); end
   endtask
   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) cyc(1'b1, 1'b1, 1'b1);
      check_zero("reset");
      resetn = 1'b1;
      m_q.delete();
   endtask
   task automatic test_patterns();
      int s0;
      for (int m = 1; m >= 0; m--) begin
         s0 = starts;
         feed(m, 0, 1'b0);
         check_result(m == 1 ? "ones" : "zeros", 1'b0, s0);
      end
      s0 = starts;
      feed(2, 0, 1'b0);
      check_result("alternating", 1'b0, s0);
   endtask
   task automatic test_overrun();
      logic [W-1:0] r1;
      int s0, n;
      s0 = starts;
      res_ready = 1'b0;
      feed(3, 0, 1'b0);
      r1 = ref_sum(exp_win());
      n = 0;
      while (!res_valid && n < 100) begin idle(1'b0); n++; end
      tests++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_first overrun: got %b want 0", overrun); end
      feed(3, 0, 1'b0);
      repeat (25) idle(1'b0);
      tests += 4;
      if (res_valid !== 1'b1) begin fails++; $display("FAIL ovr held valid: got %b want 1", res_valid); end
      if (res_out !== r1) begin fails++; $display("FAIL ovr held res_out: got %0d want %0d", $signed(res_out), $signed(r1)); end
      if (overrun !== 1'b1) begin fails++; $display("FAIL ovr overrun: got %b want 1", overrun); end
      if (starts - s0 != 2) begin fails++; $display("FAIL ovr starts: got %0d want 2", starts - s0); end
      res_ready = 1'b1;
      idle(1'b0);
      tests += 2;
      if (res_valid !== 1'b0) begin fails++; $display("FAIL ovr handshake res_valid: got %b want 0", res_valid); end
      if (overrun !== 1'b1) begin fails++; $display("FAIL ovr sticky: got %b want 1", overrun); end
   endtask
   task automatic test_enable_toggle();
      int s0;
      s0 = starts;
      feed(1, 0, 1'b1);
      check_result("toggle", 1'b1, s0);
   endtask
   task automatic test_reset_mid();
      int s0;
      feed(3, 0, 1'b0);
      repeat (5) idle(1'b0);
      resetn = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      check_zero("mid_reset");
      resetn = 1'b1;
      m_q.delete();
      s0 = starts;
      feed(3, 0, 1'b0);
      check_result("after_reset", 1'b0, s0);
   endtask
   task automatic test_gaps();
      int s0;
      s0 = starts;
      feed(3, 2, 1'b0);
      check_result("gaps", 1'b0, s0);
   endtask
   task automatic test_random();
      int s0;
      for (int r = 0; r < 4; r++) begin
         s0 = starts;
         feed(3, int'($urandom_range(0, 2)), 1'($urandom));
         check_result("random", 1'b0, s0);
      end
   endtask
   initial begin
      test_reset();
      test_patterns();
      test_overrun();
      test_reset_mid();
      test_enable_toggle();
      test_gaps();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
